dac_spi_multi: RTL and testbench

Parametrised multi-channel SPI master for serial DACs, clocked directly on sclk.
- Holds a shadow register and a dirty flag per channel. Host writes update the shadow registers at any time.
- A start request transmits one frame per dirty channel, lowest index first, then pulses LDAC so all outputs update together.
- MISO is shifted in during every frame and presented as readback.
- Sits between the sample/control logic and the external DAC pins.

---
 rtl/dac_spi_multi.sv | 174 +++++++++++++++++
 tb/tb_dac_spi_multi.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_multi.sv
// dac_spi_multi: multi-channel SPI master for serial DACs, clocked directly on sclk.
// Latency: start edge + per dirty channel (1 LOAD + FRAME_W SHIFT + CS_GAP GAP) + 1 LDAC, then done.
// Backpressure: none; start is ignored while busy or with nothing dirty, writes are always accepted.
//
// Ports:
//   sclk, n_reset           clock (also SPI clock) and async active-low reset
//   wr_en/wr_ch/wr_data     shadow register write, marks the channel dirty
//   start                   send one frame per dirty channel, lowest index first
//   busy, done              burst in progress / one-cycle end-of-burst pulse
//   dac_mosi/miso/cs/ldac_n DAC pins (cs and ldac_n active low)
//   rx_data, rx_valid       last frame shifted in on dac_miso, with update pulse
module dac_spi_multi #(
  parameter int               N_CH    = 2,
  parameter int               DATA_W  = 8,
  parameter int               FRAME_W = 16,
  parameter int               CFG_W   = 3,
  parameter logic [CFG_W-1:0] CFG     = 3'b111,
  parameter int               CS_GAP  = 1,
  parameter bit               LDAC_EN = 1'b1,
  parameter int               CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               sclk,
  input  logic               n_reset,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               dac_mosi,
  input  logic               dac_miso,
  output logic               dac_cs,
  output logic               dac_ldac_n,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_LDAC   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam int BC_W = $clog2(FRAME_W + 1);
  localparam int GC_W = $clog2(CS_GAP + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_W - 1);
  localparam logic [GC_W-1:0] LAST_GAP = GC_W'(CS_GAP - 1);

  generate
    if (CH_W + CFG_W + DATA_W > FRAME_W) begin : g_bad_frame
      $error("dac_spi_multi: channel, config and data fields do not fit in FRAME_W");
    end
  endgenerate

  logic [2:0]         r_state;
  logic [CH_W-1:0]    r_ch;
  logic [N_CH-1:0]    r_dirty;
  logic [DATA_W-1:0]  r_shadow [N_CH];
  logic [FRAME_W-1:0] r_tx;
  logic [FRAME_W-1:0] r_rx;
  logic [BC_W-1:0]    r_bit_cnt;
  logic [GC_W-1:0]    r_gap_cnt;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;

  logic               w_wr_ok;
  logic               w_any_dirty;
  logic [CH_W-1:0]    w_sel;
  logic [FRAME_W-1:0] w_frame;
  logic [FRAME_W-1:0] w_rx_next;

  // Out-of-range channel writes are dropped (only possible when N_CH is not a power of two).
  assign w_wr_ok   = wr_en && (32'(wr_ch) < N_CH);
  assign w_rx_next = {r_rx[FRAME_W-2:0], dac_miso};

  // Lowest-index dirty channel wins.
  always_comb begin
    w_any_dirty = |r_dirty;
    w_sel       = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_dirty[i]) w_sel = CH_W'(i);
    end
  end

  // Frame = {channel, config, sample, zero pad}, built field by field so a zero-width pad is legal.
  always_comb begin
    w_frame = '0;
    w_frame[FRAME_W-1 -: CH_W]                 = r_ch;
    w_frame[FRAME_W-CH_W-1 -: CFG_W]           = CFG;
    w_frame[FRAME_W-CH_W-CFG_W-1 -: DATA_W]    = r_shadow[r_ch];
  end

  // Shadow registers and dirty flags. The write is ordered after the LOAD clear so a
  // same-cycle rewrite of the channel being loaded keeps it dirty for another frame.
  always_ff @(posedge sclk or negedge n_reset) begin
    if (!n_reset) begin
      r_dirty <= '0;
      for (int i = 0; i < N_CH; i++) r_shadow[i] <= '0;
    end else begin
      if (r_state == S_LOAD) r_dirty[r_ch] <= 1'b0;
      if (w_wr_ok) begin
        r_dirty[wr_ch]  <= 1'b1;
        r_shadow[wr_ch] <= wr_data;
      end
    end
  end

  always_ff @(posedge sclk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && w_any_dirty) begin
            r_ch    <= w_sel;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_tx      <= w_frame;
          r_bit_cnt <= '0;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          r_tx      <= r_tx << 1;
          r_rx      <= w_rx_next;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            // Publish the full frame including the bit sampled on this last edge.
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
            r_gap_cnt  <= '0;
            r_state    <= S_GAP;
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + 1'b1;
          if (r_gap_cnt == LAST_GAP) begin
            // Channels rewritten during the burst are picked up here, before LDAC.
            if (w_any_dirty) begin
              r_ch    <= w_sel;
              r_state <= S_LOAD;
            end else if (LDAC_EN) begin
              r_state <= S_LDAC;
            end else begin
              r_state <= S_FINISH;
            end
          end
        end
        S_LDAC:   r_state <= S_FINISH;
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FINISH);
  assign dac_cs     = (r_state != S_SHIFT);
  assign dac_ldac_n = (r_state != S_LDAC);
  assign dac_mosi   = (r_state == S_SHIFT) & r_tx[FRAME_W-1];
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;

endmodule

// File: tb/tb_dac_spi_multi.sv
`timescale 1ns/1ps
module tb_dac_spi_multi;
  localparam int N_CH    = 2;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 16;
  localparam int CFG_W   = 3;
  localparam int CS_GAP  = 1;
  localparam int CH_W    = 1;
  localparam int CFG_V   = 7;

  logic               sclk;
  logic               n_reset;
  logic               wr_en;
  logic [CH_W-1:0]    wr_ch;
  logic [DATA_W-1:0]  wr_data;
  logic               start;
  logic               busy;
  logic               done;
  logic               dac_mosi;
  logic               dac_miso;
  logic               dac_cs;
  logic               dac_ldac_n;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Pin-level observer state
  logic [FRAME_W-1:0] frames[$];
  int                 lens[$];
  int                 gaps[$];
  logic [FRAME_W-1:0] cur        = '0;
  int                 cur_len    = 0;
  int                 hi_run     = 0;
  bit                 had_frame  = 0;
  int                 ldac_cnt   = 0;
  int                 done_cnt   = 0;
  int                 done_cyc   = 0;
  int                 rxv_cnt    = 0;
  logic [FRAME_W-1:0] rx_at_gap  = '0;
  logic               rxv_at_gap = 1'b0;
  logic [FRAME_W-1:0] miso_pat   = '0;

  dac_spi_multi dut (
    .sclk(sclk), .n_reset(n_reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .dac_mosi(dac_mosi), .dac_miso(dac_miso),
    .dac_cs(dac_cs), .dac_ldac_n(dac_ldac_n), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  always @(posedge sclk) cyc++;

  // Observes the DAC pins on the falling edge and plays back miso_pat during chip select.
  always @(negedge sclk) begin
    if (dac_cs === 1'b0) begin
      if (cur_len == 0 && had_frame) gaps.push_back(hi_run);
      checks++;
      if (dac_ldac_n !== 1'b1) begin
        errors++;
        $display("FAIL ldac_while_cs: dac_ldac_n=%b required 1", dac_ldac_n);
      end
      if (cur_len < FRAME_W) dac_miso = miso_pat[FRAME_W-1-cur_len];
      else dac_miso = 1'b0;
      cur = {cur[FRAME_W-2:0], dac_mosi};
      cur_len++;
    end else begin
      dac_miso = 1'b0;
      if (cur_len != 0) begin
        frames.push_back(cur);
        lens.push_back(cur_len);
        cur        = '0;
        cur_len    = 0;
        had_frame  = 1;
        hi_run     = 1;
        rxv_at_gap = rx_valid;
        rx_at_gap  = rx_data;
      end else if (had_frame) begin
        hi_run++;
      end
    end
    if (dac_ldac_n === 1'b0) ldac_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rx_valid === 1'b1) rxv_cnt++;
  end

  // Reference frame from the field rule: {channel, config, sample, zero pad}.
  function automatic logic [FRAME_W-1:0] model_frame(input int ch, input int data);
    return FRAME_W'(ch * (1 << (FRAME_W - CH_W))
                  + CFG_V * (1 << (FRAME_W - CH_W - CFG_W))
                  + data * (1 << (FRAME_W - CH_W - CFG_W - DATA_W)));
  endfunction

  // Cycles from the start edge to done for n frames.
  function automatic int exp_lat(input int n);
    return n * (1 + FRAME_W + CS_GAP) + 1;
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic clr();
    frames.delete();
    lens.delete();
    gaps.delete();
    had_frame = 0;
    hi_run    = 0;
    ldac_cnt  = 0;
    done_cnt  = 0;
    done_cyc  = 0;
    rxv_cnt   = 0;
    rxv_at_gap = 1'b0;
    rx_at_gap  = '0;
  endtask

  task automatic do_write(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_data = DATA_W'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n0;
    n0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt > n0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_cs_low(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dac_cs === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    #3;
    checks++; if (dac_cs !== 1'b1)     begin errors++; $display("FAIL rst_cs: got %b want 1", dac_cs); end
    checks++; if (dac_ldac_n !== 1'b1) begin errors++; $display("FAIL rst_ldac: got %b want 1", dac_ldac_n); end
    checks++; if (dac_mosi !== 1'b0)   begin errors++; $display("FAIL rst_mosi: got %b want 0", dac_mosi); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL rst_rxv: got %b want 0", rx_valid); end
    checks++; if (rx_data !== '0)      begin errors++; $display("FAIL rst_rxdata: got %h want 0", rx_data); end
    tick(); tick();
    n_reset = 1'b1;
    tick();
    clr();
  endtask

  task automatic test_single();
    logic [DATA_W-1:0]  d;
    logic [FRAME_W-1:0] exp;
    int s;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 8'hA5 : DATA_W'($urandom);
      clr();
      do_write(0, int'(d));
      pulse_start(s);
      wait_done(80, ok);
      exp = model_frame(0, int'(d));
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout: no done within 80 cycles"); end
      checks++; if (frames.size() != 1) begin errors++; $display("FAIL single_nframes: got %0d want 1", frames.size()); end
      if (frames.size() > 0) begin
        checks++; if (frames[0] !== exp) begin errors++; $display("FAIL single_frame: got %h want %h", frames[0], exp); end
        checks++; if (lens[0] != FRAME_W) begin errors++; $display("FAIL single_cs_len: got %0d want %0d", lens[0], FRAME_W); end
      end
      checks++; if (ldac_cnt != 1) begin errors++; $display("FAIL single_ldac: got %0d want 1", ldac_cnt); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (done_cyc - s != exp_lat(1)) begin errors++; $display("FAIL single_latency: got %0d want %0d", done_cyc - s, exp_lat(1)); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    end
  endtask

  task automatic test_two();
    logic [DATA_W-1:0] d0, d1;
    int s;
    bit ok;
    d1 = 8'h3C;
    d0 = 8'hFF;
    clr();
    do_write(1, int'(d1));
    do_write(0, int'(d0));
    pulse_start(s);
    wait_done(120, ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_timeout: no done within 120 cycles"); end
    checks++; if (frames.size() != 2) begin errors++; $display("FAIL two_nframes: got %0d want 2", frames.size()); end
    if (frames.size() == 2) begin
      checks++; if (frames[0] !== model_frame(0, int'(d0))) begin errors++; $display("FAIL two_frame0: got %h want %h", frames[0], model_frame(0, int'(d0))); end
      checks++; if (frames[1] !== model_frame(1, int'(d1))) begin errors++; $display("FAIL two_frame1: got %h want %h", frames[1], model_frame(1, int'(d1))); end
    end
    checks++; if (gaps.size() != 1) begin errors++; $display("FAIL two_ngaps: got %0d want 1", gaps.size()); end
    if (gaps.size() > 0) begin
      // cs stays high through GAP plus the LOAD of the next frame.
      checks++; if (gaps[0] != CS_GAP + 1) begin errors++; $display("FAIL two_cs_gap: got %0d want %0d", gaps[0], CS_GAP + 1); end
    end
    checks++; if (ldac_cnt != 1) begin errors++; $display("FAIL two_ldac: got %0d want 1", ldac_cnt); end
    checks++; if (done_cyc - s != exp_lat(2)) begin errors++; $display("FAIL two_latency: got %0d want %0d", done_cyc - s, exp_lat(2)); end
  endtask

  task automatic test_random();
    int last[N_CH];
    int order[$];
    logic [FRAME_W-1:0] expq[$];
    int mask, s, tmp, j;
    bit ok;
    for (int it = 0; it < 8; it++) begin
      clr();
      order.delete();
      expq.delete();
      mask = $urandom_range(1, (1 << N_CH) - 1);
      for (int c = 0; c < N_CH; c++) if (mask[c]) order.push_back(c);
      for (int k = order.size() - 1; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = order[k]; order[k] = order[j]; order[j] = tmp;
      end
      for (int k = 0; k < order.size(); k++) begin
        last[order[k]] = $urandom_range(0, 255);
        do_write(order[k], last[order[k]]);
      end
      if ($urandom_range(0, 1) == 1) begin
        tmp = order[0];
        last[tmp] = $urandom_range(0, 255);
        do_write(tmp, last[tmp]);
      end
      for (int c = 0; c < N_CH; c++) if (mask[c]) expq.push_back(model_frame(c, last[c]));
      pulse_start(s);
      wait_done(150, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout: iter %0d no done", it); end
      checks++; if (frames.size() != expq.size()) begin errors++; $display("FAIL rand_nframes: iter %0d got %0d want %0d", it, frames.size(), expq.size()); end
      for (int k = 0; k < expq.size() && k < frames.size(); k++) begin
        checks++; if (frames[k] !== expq[k]) begin errors++; $display("FAIL rand_frame: iter %0d idx %0d got %h want %h", it, k, frames[k], expq[k]); end
      end
      checks++; if (ldac_cnt != 1) begin errors++; $display("FAIL rand_ldac: iter %0d got %0d want 1", it, ldac_cnt); end
      checks++; if (done_cyc - s != exp_lat(expq.size())) begin errors++; $display("FAIL rand_latency: iter %0d got %0d want %0d", it, done_cyc - s, exp_lat(expq.size())); end
    end
  endtask

  task automatic test_no_dirty();
    int s, busy_seen;
    clr();
    busy_seen = 0;
    pulse_start(s);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL nodirty_busy: busy cycles %0d want 0", busy_seen); end
    checks++; if (frames.size() != 0) begin errors++; $display("FAIL nodirty_frames: got %0d want 0", frames.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL nodirty_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_start_busy();
    int s, s2;
    bit ok;
    clr();
    do_write(1, $urandom_range(0, 255));
    pulse_start(s);
    for (int i = 0; i < 5; i++) tick();
    pulse_start(s2);
    wait_done(80, ok);
    for (int i = 0; i < 40; i++) tick();
    checks++; if (!ok) begin errors++; $display("FAIL busystart_timeout: no done"); end
    checks++; if (frames.size() != 1) begin errors++; $display("FAIL busystart_frames: got %0d want 1", frames.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busystart_done: got %0d want 1", done_cnt); end
    checks++; if (done_cyc - s != exp_lat(1)) begin errors++; $display("FAIL busystart_latency: got %0d want %0d", done_cyc - s, exp_lat(1)); end
  endtask

  task automatic test_rewrite();
    logic [DATA_W-1:0] old;
    int s;
    bit ok;
    old = DATA_W'($urandom_range(0, 255));
    clr();
    do_write(0, int'(old));
    pulse_start(s);
    wait_cs_low(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rewrite_cs_timeout: cs never low"); end
    tick(); tick(); tick();
    do_write(0, 'h11);
    wait_done(120, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rewrite_timeout: no done"); end
    checks++; if (frames.size() != 2) begin errors++; $display("FAIL rewrite_nframes: got %0d want 2", frames.size()); end
    if (frames.size() == 2) begin
      checks++; if (frames[0] !== model_frame(0, int'(old))) begin errors++; $display("FAIL rewrite_frame0: got %h want %h", frames[0], model_frame(0, int'(old))); end
      checks++; if (frames[1] !== model_frame(0, 'h11)) begin errors++; $display("FAIL rewrite_frame1: got %h want %h", frames[1], model_frame(0, 'h11)); end
    end
    checks++; if (ldac_cnt != 1) begin errors++; $display("FAIL rewrite_ldac: got %0d want 1", ldac_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rewrite_done: got %0d want 1", done_cnt); end
    checks++; if (done_cyc - s != exp_lat(2)) begin errors++; $display("FAIL rewrite_latency: got %0d want %0d", done_cyc - s, exp_lat(2)); end
  endtask

  task automatic test_miso();
    logic [FRAME_W-1:0] pat;
    int s;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      pat = (it == 0) ? 16'h1234 : FRAME_W'($urandom);
      miso_pat = pat;
      clr();
      do_write(1, $urandom_range(0, 255));
      pulse_start(s);
      wait_done(80, ok);
      checks++; if (!ok) begin errors++; $display("FAIL miso_timeout: no done"); end
      checks++; if (rx_at_gap !== pat) begin errors++; $display("FAIL miso_rx_gap: got %h want %h", rx_at_gap, pat); end
      checks++; if (rxv_at_gap !== 1'b1) begin errors++; $display("FAIL miso_rxv_first_gap: got %b want 1", rxv_at_gap); end
      checks++; if (rxv_cnt != 1) begin errors++; $display("FAIL miso_rxv_cnt: got %0d want 1", rxv_cnt); end
      checks++; if (rx_data !== pat) begin errors++; $display("FAIL miso_rx_hold: got %h want %h", rx_data, pat); end
    end
    miso_pat = '0;
  endtask

  task automatic test_reset_mid();
    int s;
    bit ok;
    clr();
    do_write(0, $urandom_range(0, 255));
    do_write(1, $urandom_range(0, 255));
    pulse_start(s);
    wait_cs_low(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_cs_timeout: cs never low"); end
    tick(); tick(); tick(); tick();
    #1 n_reset = 1'b0;
    #1;
    checks++; if (dac_cs !== 1'b1)     begin errors++; $display("FAIL rstmid_cs: got %b want 1", dac_cs); end
    checks++; if (dac_ldac_n !== 1'b1) begin errors++; $display("FAIL rstmid_ldac: got %b want 1", dac_ldac_n); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (dac_mosi !== 1'b0)   begin errors++; $display("FAIL rstmid_mosi: got %b want 0", dac_mosi); end
    tick(); tick();
    n_reset = 1'b1;
    tick();
    clr();
    for (int i = 0; i < 40; i++) tick();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_done: got %0d want 0", done_cnt); end
    checks++; if (ldac_cnt != 0) begin errors++; $display("FAIL rstmid_ldac_pulse: got %0d want 0", ldac_cnt); end
    checks++; if (frames.size() != 0) begin errors++; $display("FAIL rstmid_frames: got %0d want 0", frames.size()); end
    pulse_start(s);
    for (int i = 0; i < 30; i++) tick();
    checks++; if (frames.size() != 0) begin errors++; $display("FAIL rstmid_start_frames: got %0d want 0", frames.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_start_done: got %0d want 0", done_cnt); end
  endtask

  initial begin
    n_reset = 1'b1;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_data = '0;
    start   = 1'b0;
    dac_miso = 1'b0;
    #2;
    test_reset();
    test_single();
    test_two();
    test_random();
    test_no_dirty();
    test_start_busy();
    test_rewrite();
    test_miso();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
